// File: rtl/alu_share_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_pkg
//  Description : Shared widths and slot state encoding for the ALU sharing
//                arbiter (two requesters, one lab1_1 ALU, one result slot).
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_share_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned ID_W   = 1;

    // Result slot occupancy
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage : alu_share_pkg
`default_nettype wire

// File: rtl/alu_share_pick.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_pick
//  Description : Combinational winner selection between two requesters.
//                Lone valid wins; otherwise a starving requester wins;
//                otherwise the strictly lower op wins; ties alternate away
//                from the last grant. Output is one-hot, or zero when idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_share_pick
    import alu_share_pkg::*;
(
    input  logic [1:0]      i_valid,
    input  logic [OP_W-1:0] i_op0,
    input  logic [OP_W-1:0] i_op1,
    input  logic [1:0]      i_starve,
    input  logic [ID_W-1:0] i_last_grant,
    output logic [1:0]      o_grant
);

    // Resolve the winner in priority order
    always_comb begin
        o_grant = 2'b00;
        unique case (i_valid)
            2'b01: o_grant = 2'b01;
            2'b10: o_grant = 2'b10;
            2'b11: begin
                if (i_starve[0]) begin
                    o_grant = 2'b01;
                end else if (i_starve[1]) begin
                    o_grant = 2'b10;
                end else if (i_op0 < i_op1) begin
                    o_grant = 2'b01;
                end else if (i_op1 < i_op0) begin
                    o_grant = 2'b10;
                end else if (i_last_grant == 1'b0) begin
                    o_grant = 2'b10;
                end else begin
                    o_grant = 2'b01;
                end
            end
            default: o_grant = 2'b00;
        endcase
    end

endmodule : alu_share_pick
`default_nettype wire

// File: rtl/lab1_1.sv
`default_nettype none
// ============================================================================
//  Module      : lab1_1
//  Description : 4-bit combinational ALU.
//                op 00: a + b, 01: a - b, 10: a & b, 11: a | b
//                (arithmetic wraps modulo 16).
//  Revision    : 1.0 - initial release
// ============================================================================
module lab1_1
    import alu_share_pkg::*;
(
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_d
);

    // Select the operation result
    always_comb begin
        o_d = '0;
        unique case (i_op)
            2'b00:   o_d = i_a + i_b;
            2'b01:   o_d = i_a - i_b;
            2'b10:   o_d = i_a & i_b;
            2'b11:   o_d = i_a | i_b;
            default: o_d = '0;
        endcase
    end

endmodule : lab1_1
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Shares one lab1_1 ALU between two valid/ready requesters.
//                The winner is accepted combinationally while the result
//                slot can take data; its ALU result and ID are registered
//                into a one-entry output slot that honours backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ID_W-1:0]   out_id
);

    localparam logic [CNT_W-1:0] c_starve_lim = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

    slot_state_t        r_state;
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic [ID_W-1:0]    r_out_id;
    logic [ID_W-1:0]    r_last_grant;
    logic [CNT_W-1:0]   r_starve_cnt0;
    logic [CNT_W-1:0]   r_starve_cnt1;

    logic               w_slot_free;
    logic [1:0]         w_starve;
    logic [1:0]         w_pick;
    logic [1:0]         w_grant;
    logic               w_any_grant;
    logic [ID_W-1:0]    w_win_id;
    logic [OP_W-1:0]    w_win_op;
    logic [DATA_W-1:0]  w_win_a;
    logic [DATA_W-1:0]  w_win_b;
    logic [DATA_W-1:0]  w_alu_d;

    // The slot can load when empty or when its current result leaves now
    assign w_slot_free = ~r_out_valid | out_ready;
    assign w_starve    = {(r_starve_cnt1 >= c_starve_lim), (r_starve_cnt0 >= c_starve_lim)};

    alu_share_pick u_pick (
        .i_valid      ({req1_valid, req0_valid}),
        .i_op0        (req0_op),
        .i_op1        (req1_op),
        .i_starve     (w_starve),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick)
    );

    // A pick only turns into a grant when the slot can take the result
    assign w_grant     = w_pick & {2{w_slot_free}};
    assign w_any_grant = |w_grant;
    assign w_win_id    = w_grant[1];

    // Ready is withheld during reset so nothing is accepted and then dropped
    assign req0_ready = w_grant[0] & ~rst;
    assign req1_ready = w_grant[1] & ~rst;

    // Winner operand mux feeding the single shared ALU
    assign w_win_op = w_grant[1] ? req1_op : req0_op;
    assign w_win_a  = w_grant[1] ? req1_a  : req0_a;
    assign w_win_b  = w_grant[1] ? req1_b  : req0_b;

    lab1_1 u_alu (
        .i_op (w_win_op),
        .i_a  (w_win_a),
        .i_b  (w_win_b),
        .o_d  (w_alu_d)
    );

    // Result slot FSM with registered outputs and grant history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= EMPTY;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_id     <= '0;
            r_last_grant <= 1'b1;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_any_grant) begin
                        r_state      <= FULL;
                        r_out_valid  <= 1'b1;
                        r_out_data   <= w_alu_d;
                        r_out_id     <= w_win_id;
                        r_last_grant <= w_win_id;
                    end
                end
                FULL: begin
                    if (w_any_grant) begin
                        r_out_data   <= w_alu_d;
                        r_out_id     <= w_win_id;
                        r_last_grant <= w_win_id;
                    end else if (out_ready) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Starvation counters move only on cycles that grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt0 <= '0;
            r_starve_cnt1 <= '0;
        end else if (w_any_grant) begin
            if (w_grant[0] || !req0_valid) begin
                r_starve_cnt0 <= '0;
            end else if (r_starve_cnt0 < c_starve_lim) begin
                r_starve_cnt0 <= r_starve_cnt0 + c_cnt_one;
            end
            if (w_grant[1] || !req1_valid) begin
                r_starve_cnt1 <= '0;
            end else if (r_starve_cnt1 < c_starve_lim) begin
                r_starve_cnt1 <= r_starve_cnt1 + c_cnt_one;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;

endmodule : alu_share_arbiter
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_share_arbiter
//  Description : Self-checking bench for alu_share_arbiter. Expected results
//                are pushed to a scoreboard queue at acceptance and popped
//                when the slot presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [1:0] req0_op = '0, req1_op = '0;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic       out_id;

    int checks = 0;
    int errors = 0;
    logic [4:0] sb_q[$];
    logic [4:0] exp_e;

    alu_share_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] alu_model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({req1_ready, req0_ready} !== 2'b00) begin
                errors++;
                $display("FAIL reset_ready cycle %0d got %b exp 00", i, {req1_ready, req0_ready});
            end
            checks++;
            if ({out_valid, out_id, out_data} !== 6'b0) begin
                errors++;
                $display("FAIL reset_out cycle %0d got v=%b id=%b d=%h exp 0/0/0", i, out_valid, out_id, out_data);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 4'h6; req0_b = 4'h3;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL single_ready got %b exp 01", {req1_ready, req0_ready});
        end
        sb_q.push_back({1'b0, alu_model(2'b01, 4'h6, 4'h3)});
        step();
        req0_valid = 1'b0;
        checks++;
        exp_e = sb_q.pop_front();
        if ({out_valid, out_id, out_data} !== {1'b1, exp_e}) begin
            errors++;
            $display("FAIL single_result got v=%b id=%b d=%h exp v=1 id=%b d=%h", out_valid, out_id, out_data, exp_e[4], exp_e[3:0]);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain got out_valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_op_priority();
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b10; req0_a = 4'h9; req0_b = 4'h5;
        req1_valid = 1'b1; req1_op = 2'b01; req1_a = 4'h7; req1_b = 4'h2;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            errors++;
            $display("FAIL op_prio_ready got %b exp 10", {req1_ready, req0_ready});
        end
        sb_q.push_back({1'b1, alu_model(2'b01, 4'h7, 4'h2)});
        step();
        req1_valid = 1'b0;
        checks++;
        exp_e = sb_q.pop_front();
        if ({out_valid, out_id, out_data} !== {1'b1, exp_e}) begin
            errors++;
            $display("FAIL op_prio_result got v=%b id=%b d=%h exp id=%b d=%h", out_valid, out_id, out_data, exp_e[4], exp_e[3:0]);
        end
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL op_prio_loser_ready got %b exp 01", {req1_ready, req0_ready});
        end
        sb_q.push_back({1'b0, alu_model(2'b10, 4'h9, 4'h5)});
        step();
        req0_valid = 1'b0;
        checks++;
        exp_e = sb_q.pop_front();
        if ({out_valid, out_id, out_data} !== {1'b1, exp_e}) begin
            errors++;
            $display("FAIL op_prio_second got v=%b id=%b d=%h exp id=%b d=%h", out_valid, out_id, out_data, exp_e[4], exp_e[3:0]);
        end
        step();
    endtask

    task automatic test_round_robin();
        logic e;
        do_reset();
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 4'h1; req0_b = 4'h2;
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 4'hA; req1_b = 4'h3;
        for (int i = 0; i < 4; i++) begin
            e = (i % 2 == 1);
            #1;
            checks++;
            if ({req1_ready, req0_ready} !== (e ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL rr_ready grant %0d got %b exp id %b", i, {req1_ready, req0_ready}, e);
            end
            sb_q.push_back({e, e ? alu_model(2'b00, req1_a, req1_b) : alu_model(2'b00, req0_a, req0_b)});
            step();
            checks++;
            exp_e = sb_q.pop_front();
            if ({out_valid, out_id, out_data} !== {1'b1, exp_e}) begin
                errors++;
                $display("FAIL rr_result grant %0d got v=%b id=%b d=%h exp id=%b d=%h", i, out_valid, out_id, out_data, exp_e[4], exp_e[3:0]);
            end
            if (e) begin
                req1_a = 4'($urandom_range(0, 15)); req1_b = 4'($urandom_range(0, 15));
            end else begin
                req0_a = 4'($urandom_range(0, 15)); req0_b = 4'($urandom_range(0, 15));
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
    endtask

    task automatic test_starvation();
        logic [5:0] seq;
        logic e;
        seq = 6'b101111;   // bit i = expected winner of grant i
        do_reset();
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b11; req0_a = 4'h4; req0_b = 4'h1;
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 4'h5; req1_b = 4'h6;
        for (int i = 0; i < 6; i++) begin
            e = seq[i];
            #1;
            checks++;
            if ({req1_ready, req0_ready} !== (e ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL starve_ready grant %0d got %b exp id %b", i, {req1_ready, req0_ready}, e);
            end
            sb_q.push_back({e, e ? alu_model(2'b00, req1_a, req1_b) : alu_model(2'b11, req0_a, req0_b)});
            step();
            checks++;
            exp_e = sb_q.pop_front();
            if ({out_valid, out_id, out_data} !== {1'b1, exp_e}) begin
                errors++;
                $display("FAIL starve_result grant %0d got v=%b id=%b d=%h exp id=%b d=%h", i, out_valid, out_id, out_data, exp_e[4], exp_e[3:0]);
            end
            if (e) begin
                req1_a = 4'($urandom_range(0, 15)); req1_b = 4'($urandom_range(0, 15));
            end else begin
                req0_a = 4'($urandom_range(0, 15)); req0_b = 4'($urandom_range(0, 15));
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req0_op = 2'($urandom_range(0, 3));
            req0_a = 4'($urandom_range(0, 15));
            req0_b = 4'($urandom_range(0, 15));
            #1;
            checks++;
            if ({req1_ready, req0_ready} !== 2'b01) begin
                errors++;
                $display("FAIL b2b_ready beat %0d got %b exp 01", i, {req1_ready, req0_ready});
            end
            sb_q.push_back({1'b0, alu_model(req0_op, req0_a, req0_b)});
            step();
            checks++;
            exp_e = sb_q.pop_front();
            if ({out_valid, out_id, out_data} !== {1'b1, exp_e}) begin
                errors++;
                $display("FAIL b2b_result beat %0d got v=%b id=%b d=%h exp id=%b d=%h", i, out_valid, out_id, out_data, exp_e[4], exp_e[3:0]);
            end
        end
        req0_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got out_valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b10; req0_a = 4'hC; req0_b = 4'hA;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_fill_ready got %b exp 01", {req1_ready, req0_ready});
        end
        sb_q.push_back({1'b0, alu_model(2'b10, 4'hC, 4'hA)});
        step();
        req0_op = 2'b11; req0_a = 4'h3; req0_b = 4'h4;
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 4'h1; req1_b = 4'h1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({req1_ready, req0_ready} !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold_ready cycle %0d got %b exp 00", i, {req1_ready, req0_ready});
            end
            checks++;
            if (sb_q.size() == 0 || {out_valid, out_id, out_data} !== {1'b1, sb_q[0]}) begin
                errors++;
                $display("FAIL bp_hold_data cycle %0d got v=%b id=%b d=%h exp stable held result", i, out_valid, out_id, out_data);
            end
            step();
        end
        req1_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release_ready got %b exp 01", {req1_ready, req0_ready});
        end
        exp_e = sb_q.pop_front();
        sb_q.push_back({1'b0, alu_model(2'b11, 4'h3, 4'h4)});
        step();
        req0_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        exp_e = sb_q.pop_front();
        if ({out_valid, out_id, out_data} !== {1'b1, exp_e}) begin
            errors++;
            $display("FAIL bp_no_bubble got v=%b id=%b d=%h exp v=1 id=%b d=%h", out_valid, out_id, out_data, exp_e[4], exp_e[3:0]);
        end
        rst = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_reset_drop got out_valid=%b exp 0", out_valid);
        end
        rst = 1'b0;
        sb_q.delete();
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_op_priority();
        test_round_robin();
        test_starvation();
        test_back_to_back();
        test_backpressure();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_share_arbiter
`default_nettype wire
